// File: rtl/sprite_rom_pkg.sv
// Shared constants and types for the sprite ROM arbiter slice.
package sprite_rom_pkg;

  localparam int SPRITE_ROM_ADDR_W  = 11;
  localparam int SPRITE_ROM_DATA_W  = 16;
  localparam int SPRITE_ROM_NUM_REQ = 3;

  // Requester slots as wired in the pixel pipeline
  localparam int REQ_DINO   = 0;
  localparam int REQ_CACTUS = 1;
  localparam int REQ_GROUND = 2;

  typedef logic [$clog2(SPRITE_ROM_NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the active requester closest to ptr
// (walking upward, wrapping modulo N) wins.
module rr_arbiter #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win,
  output logic           any
);

  int best_d;
  int best_k;
  int d;

  // Rank each active requester by its wrapped distance from the pointer
  always_comb begin
    best_d = N;
    best_k = 0;
    d      = 0;
    win    = '0;
    any    = |req;
    for (int k = 0; k < N; k++) begin
      if (req[k]) begin
        d = (k + N - int'(ptr)) % N;
        if (d < best_d) begin
          best_d = d;
          best_k = k;
        end
      end
    end
    for (int k = 0; k < N; k++)
      win[k] = any && (k == best_k);
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one synchronous sprite ROM between pixel-pipeline
// requesters; read words are routed back by a tag pipeline at fixed latency.
module sprite_rom_arbiter
  import sprite_rom_pkg::*;
#(
  parameter int NUM_REQ = SPRITE_ROM_NUM_REQ,
  parameter int ADDR_W  = SPRITE_ROM_ADDR_W,
  parameter int DATA_W  = SPRITE_ROM_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0]             ptr;
  logic [NUM_REQ-1:0]         masked;
  logic [NUM_REQ-1:0]         win;
  logic                       any;
  logic [IDW-1:0]             widx;
  logic [ADDR_W-1:0]          sel_addr;
  logic [NUM_REQ-1:0]         rsp_dec;

  // In-flight reads: valid bits and requester ids, one stage per clock
  logic [ROM_LAT:0]           vld_pipe;
  logic [ROM_LAT:0][IDW-1:0]  id_pipe;

  // A requester being granted this cycle still shows req; mask it so a
  // held request cannot win twice in a row.
  assign masked = req & ~gnt;

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
    .req (masked),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // Encode the winner and select its address
  always_comb begin
    widx     = '0;
    sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win[k]) begin
        widx     = IDW'(k);
        sel_addr = req_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Decode the oldest tag into a one-hot response strobe
  always_comb begin
    rsp_dec = '0;
    for (int k = 0; k < NUM_REQ; k++)
      rsp_dec[k] = vld_pipe[ROM_LAT] && (id_pipe[ROM_LAT] == IDW'(k));
  end

  // Grant, address, pointer and tag pipeline registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gnt       <= '0;
      rom_addr  <= '0;
      ptr       <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      gnt <= win;
      if (any) begin
        rom_addr <= sel_addr;
        ptr      <= (int'(widx) == NUM_REQ - 1) ? '0 : widx + 1'b1;
      end
      vld_pipe[0] <= any;
      id_pipe[0]  <= widx;
      for (int s = 1; s <= ROM_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
      rsp_valid <= rsp_dec;
      if (vld_pipe[ROM_LAT])
        rsp_data <= rom_data;
    end
  end

  assign busy = (|gnt) | (|vld_pipe);

endmodule
